i2c_target_regs: RTL
====================

Name: i2c_target_regs

Overview:
- I2C target (slave) responder with a small register file; the downstream peer of the team's I2C master driver on the same SCL/SDA pair.
- Serves as an on-chip peripheral model and as the loopback target for master verification.
- Decodes START/STOP, matches a 7-bit address, and ACKs it.
- Writes: first data byte sets the register pointer; later bytes write registers. Reads: returns registers from the pointer with auto-increment.
- A local-side port allows preloading registers and reports each I2C write.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target answers to.
- NUM_REGS, 16, number of 8-bit registers; must be a power of two.
- AW, 4, pointer/register index width = log2(NUM_REGS).

Ports:
- clk  in  1  system clock; must be ≥ 8x the SCL frequency.
- rst  in  1  reset, asynchronous, active-high.
- I2C_SCL  in  1  bus clock from the master.
- I2C_SDA  inout  1  bus data; this block drives only 0 or 1'bz.
- loc_we  in  1  local register write strobe.
- loc_addr  in  AW  local write index.
- loc_wdata  in  8  local write data.
- wr_strobe  out  1  one-cycle pulse when an I2C data byte is written to a register.
- wr_addr  out  AW  index written, valid with wr_strobe.
- wr_data  out  8  byte written, valid with wr_strobe.
- ptr  out  AW  current register pointer.
- addressed  out  1  high from address ACK until STOP, NACK'd read, or mismatched repeated START.

Behaviour:
- Reset: SDA released (z), all registers 8'h00, ptr=0, wr_strobe=0, wr_addr=0, wr_data=0, addressed=0, FSM=IDLE. Reset mid-transfer releases SDA immediately (async).
- Input sync: SCL and SDA each pass through a 2-flop synchronizer, reset value 1. All edge detection uses the synchronized values and their 1-cycle-delayed copies.
- START = SDA 1->0 while SCL high. STOP = SDA 0->1 while SCL high. Both are recognised in every state.
  - STOP: go to IDLE, release SDA, addressed=0.
  - START (including repeated START): go to ADDR, bit_cnt=0, release SDA.
- Data sampled on SCL rising edges; SDA changed by this block only on SCL falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
  - IDLE: ignore all traffic except START.
  - ADDR: shift 8 bits, MSB first, on rising edges.
    - After the 8th rising edge, if shift[7:1]==TARGET_ADDR: on the next falling edge drive SDA=0, addressed=1, enter ADDR_ACK.
    - Mismatch: go IDLE, never drive SDA.
  - ADDR_ACK: hold SDA low through the 9th SCL high. On the 9th falling edge:
    - R/W=0: release SDA, enter WR_BYTE with first_byte=1.
    - R/W=1: drive bit 7 of reg[ptr], enter RD_BYTE.
  - WR_BYTE: shift 8 bits. After the 8th rising edge, on the falling edge drive ACK (SDA=0) and enter WR_ACK.
    - first_byte=1: ptr <= byte[AW-1:0], no register write, first_byte=0.
    - first_byte=0: reg[ptr] <= byte; wr_strobe pulses 1 cycle with wr_addr=ptr, wr_data=byte; ptr <= ptr+1.
    - The register update, strobe and pointer change occur in the clk cycle after the 8th synchronized rising edge.
  - WR_ACK: on the 9th falling edge release SDA and return to WR_BYTE. Unlimited bytes per transaction.
  - RD_BYTE: present bits 7..0 of the latched byte, one per falling edge. After the 8th falling edge release SDA and enter RD_ACK.
  - RD_ACK: sample the master's bit on the 9th rising edge.
    - 0 (ACK): ptr <= ptr+1. On the next falling edge drive bit 7 of the new reg[ptr] and re-enter RD_BYTE.
    - 1 (NACK): ptr <= ptr+1, addressed=0, go IDLE with SDA released.
- Pointer arithmetic is modulo NUM_REGS: 15+1 wraps to 0 with NUM_REGS=16.
- Read latch: the read byte is latched when entering RD_BYTE. A later local or I2C write does not alter a byte already being shifted.
- Local write: loc_we writes reg[loc_addr] <= loc_wdata in the same cycle. If it coincides with an I2C register write in the same cycle, the I2C write wins for that index; a different index is written normally. loc_we never pulses wr_strobe.
- SDA out only: the block never drives I2C_SDA to 1. Released = 1'bz; an external pull-up is assumed by the bench.

Test Plan:
- Write pointer then data: START, 0xA0 (ACK), 0x03 (ACK), 0x5A (ACK), STOP -> reg[3]=0x5A, one wr_strobe with wr_addr=3, wr_data=0x5A, ptr=4.
- Read with repeated START: preload reg[4]=0xC3 via loc_we. Sequence START, 0xA0, 0x04, repeated START, 0xA1, read one byte + NACK, STOP -> SDA carries 0xC3, ptr=5, addressed=0 after NACK.
- Address mismatch: START, 0xB0 -> SDA never driven low through the 9th clock, registers unchanged, wr_strobe stays 0.
- Burst wrap: set ptr=15, write 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22, ptr=1.
- Multi-byte read ACK: reg[6]=0x01, reg[7]=0x02; master ACKs then NACKs -> bytes 0x01, 0x02 returned, ptr=8.
- Reset mid-ACK: assert rst while ADDR_ACK drives SDA low -> SDA released in the same cycle, all registers 0, FSM=IDLE.
- Loopback with the team master: master writes data_in=0x07 to addr 0x50 -> ptr=7, master sees an ACK on both bytes.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with a small register file: START/STOP decode, 7-bit address match,
// pointer-then-data writes, auto-incrementing reads and a local preload port.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned AW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          I2C_SCL,
    inout  wire           I2C_SDA,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] ptr,
    output logic          addressed
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck
    } state_e;

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_prev_q, sda_prev_q;
    logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]    rx_byte;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          sda_oe_q, sda_oe_d;
    logic          addressed_q, addressed_d;
    logic          first_byte_q, first_byte_d;
    logic          rd_ack_q, rd_ack_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    // Synchronizers reset to 1 so an idle bus never looks like an edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I2C_SCL};
            sda_sync_q <= {sda_sync_q[0], I2C_SDA};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rd_byte_d    = rd_byte_q;
        sda_oe_d     = sda_oe_q;
        addressed_d  = addressed_q;
        first_byte_d = first_byte_q;
        rd_ack_d     = rd_ack_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        // Local write first so a same-index I2C write below overrides it.
        if (loc_we) begin
            regs_d[loc_addr] = loc_wdata;
        end

        if (stop_det) begin
            state_d     = StIdle;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = 1'b1;
                            state_d     = StAddrAck;
                        end else begin
                            addressed_d = 1'b0;
                            state_d     = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!shift_q[0]) begin
                            sda_oe_d     = 1'b0;
                            first_byte_d = 1'b1;
                            bit_cnt_d    = 4'd0;
                            state_d      = StWrByte;
                        end else begin
                            rd_byte_d = regs_q[ptr_q];
                            sda_oe_d  = ~regs_q[ptr_q][7];
                            bit_cnt_d = 4'd1;
                            state_d   = StRdByte;
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (first_byte_q) begin
                                ptr_d        = rx_byte[AW-1:0];
                                first_byte_d = 1'b0;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_strobe_d   = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = rx_byte;
                                ptr_d         = ptr_q + AW'(1);
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = StWrAck;
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWrByte;
                    end
                end
                StRdByte: begin
                    // bit_cnt counts bits already presented; the latched byte is shifted MSB first.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            rd_ack_d = 1'b0;
                            state_d  = StRdAck;
                        end else begin
                            sda_oe_d  = ~rd_byte_q[~bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise && !rd_ack_q) begin
                        ptr_d = ptr_q + AW'(1);
                        if (sda_s) begin
                            addressed_d = 1'b0;
                            state_d     = StIdle;
                        end else begin
                            rd_ack_d = 1'b1;
                        end
                    end else if (scl_fall && rd_ack_q) begin
                        rd_byte_d = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd1;
                        rd_ack_d  = 1'b0;
                        state_d   = StRdByte;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rd_byte_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            addressed_q  <= 1'b0;
            first_byte_q <= 1'b0;
            rd_ack_q     <= 1'b0;
            ptr_q        <= '0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rd_byte_q    <= rd_byte_d;
            sda_oe_q     <= sda_oe_d;
            addressed_q  <= addressed_d;
            first_byte_q <= first_byte_d;
            rd_ack_q     <= rd_ack_d;
            ptr_q        <= ptr_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            regs_q       <= regs_d;
        end
    end

    // Open-drain: only ever pull low.
    assign I2C_SDA   = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign ptr       = ptr_q;
    assign addressed = addressed_q;

endmodule
